// File: rtl/shuffle_millis_if.sv
// Controller-facing signal bundle of the deck shuffler and millisecond timebase.
// The controller holds the master side; the shuffler holds the slave side.
interface shuffle_millis_if;
    logic        shuffleFlag;
    logic        loadFlag;
    logic [5:0]  card;
    logic [31:0] time_ms;

    modport master (output shuffleFlag, input loadFlag, card, time_ms);
    modport slave  (input shuffleFlag, output loadFlag, card, time_ms);
endinterface

// File: rtl/shuffle_millis.sv
// Fisher-Yates deck shuffler that streams a 52-card permutation, plus a
// free-running millisecond counter used by the blackjack controller.
module shuffle_millis #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    shuffle_millis_if.slave bus
);
    localparam int unsigned MS_CYCLES = CLK_HZ / 1000;
    localparam int unsigned PRE_W     = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
    localparam int unsigned HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(MS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [5:0]        LAST_CARD = 6'd51;

    typedef enum logic [2:0] {IDLE, INIT, SWAP_A, SWAP_B, STREAM, DONE} state_t;

    state_t            state_q, state_d;
    logic [5:0]        idx_q, idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              load_q, load_d;
    logic [5:0]        card_q, card_d;
    logic [5:0]        j_q, a_q, b_q;
    logic              init_we, swap_rd, swap_we;

    logic [15:0]       lfsr_q;
    logic [PRE_W-1:0]  pre_q;
    logic [31:0]       time_ms_q;

    logic [5:0]        deck [52];
    logic [21:0]       prod;
    logic [5:0]        j_calc;

    // lfsr < 2^16, so the top bits of lfsr*(i+1) always land in 0..i.
    assign prod   = 22'(lfsr_q) * 22'(idx_q + 6'd1);
    assign j_calc = prod[21:16];

    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        load_d  = load_q;
        card_d  = card_q;
        init_we = 1'b0;
        swap_rd = 1'b0;
        swap_we = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.shuffleFlag) begin
                    state_d = INIT;
                    idx_d   = '0;
                end
            end
            INIT: begin
                init_we = 1'b1;
                if (idx_q == LAST_CARD) state_d = SWAP_A;
                else                    idx_d   = idx_q + 6'd1;
            end
            SWAP_A: begin
                swap_rd = 1'b1;
                state_d = SWAP_B;
            end
            SWAP_B: begin
                swap_we = 1'b1;
                if (idx_q == 6'd1) begin
                    state_d = STREAM;
                    idx_d   = '0;
                    hold_d  = '0;
                    load_d  = 1'b1;
                    // deck[0] is being rewritten on this same edge when j=0
                    card_d  = (j_q == 6'd0) ? a_q : deck[0];
                end else begin
                    state_d = SWAP_A;
                    idx_d   = idx_q - 6'd1;
                end
            end
            STREAM: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (idx_q == LAST_CARD) begin
                        state_d = DONE;
                    end else begin
                        idx_d  = idx_q + 6'd1;
                        card_d = deck[idx_q + 6'd1];
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            DONE: begin
                if (!bus.shuffleFlag) begin
                    state_d = IDLE;
                    load_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            load_q  <= 1'b0;
            card_q  <= 6'd63;
            j_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            load_q  <= load_d;
            card_q  <= card_d;
            if (swap_rd) begin
                j_q <= j_calc;
                a_q <= deck[idx_q];
                b_q <= deck[j_calc];
            end
        end
    end

    // NOTE: the deck storage has no reset; INIT rewrites every entry before use.
    always_ff @(posedge clk) begin
        if (init_we) deck[idx_q] <= idx_q;
        if (swap_we) begin
            deck[idx_q] <= b_q;
            deck[j_q]   <= a_q;
        end
    end

    // The LFSR free-runs so the permutation depends on request timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q    <= SEED;
            pre_q     <= '0;
            time_ms_q <= '0;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
            if (pre_q == PRE_LAST) begin
                pre_q     <= '0;
                time_ms_q <= time_ms_q + 32'd1;
            end else begin
                pre_q <= pre_q + PRE_W'(1);
            end
        end
    end

    assign bus.loadFlag = load_q;
    assign bus.card     = card_q;
    assign bus.time_ms  = time_ms_q;
endmodule

// File: tb/tb_shuffle_millis.sv
// Bench for shuffle_millis: a permutation model fed by a spec-level LFSR
// predicts every streamed card; a monitor checks the stream against a queue.
module tb_shuffle_millis;
    localparam int          HOLD = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    shuffle_millis_if bus ();

    shuffle_millis #(
        .CLK_HZ     (4000),
        .SEED       (SEED),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned ecount;
    always @(posedge clk or posedge rst) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    int exp_card [$];
    int exp_rise [$];
    int cap [$];
    int run_a [$];
    int run_b [$];
    int pred [52];
    int pop_n = 0;
    int last_card = 0;
    logic prev_load = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Fisher-Yates over the LFSR value seen before each swap's first cycle.
    task automatic predict(input int unsigned c);
        logic [15:0] l;
        int e, j, t;
        for (int k = 0; k < 52; k++) pred[k] = k;
        l = SEED;
        for (int unsigned n = 0; n < c; n++) l = lfsr_step(l);
        e = 0;
        for (int i = 51; i >= 1; i--) begin
            while (e < 53 + 2 * (51 - i)) begin
                l = lfsr_step(l);
                e++;
            end
            j = int'((32'(l) * 32'(i + 1)) >> 16);
            t = pred[i]; pred[i] = pred[j]; pred[j] = t;
        end
    endtask

    task automatic wait_ecount(input int unsigned n);
        @(negedge clk);
        while (ecount < n) @(negedge clk);
    endtask

    task automatic start_shuffle();
        int unsigned c;
        c = ecount;
        predict(c);
        exp_card.delete();
        exp_rise.delete();
        cap.delete();
        pop_n = 0;
        for (int p = 0; p < 52; p++) repeat (HOLD) exp_card.push_back(pred[p]);
        exp_rise.push_back(int'(c + 155));
        last_card = pred[51];
        bus.shuffleFlag = 1'b1;
    endtask

    task automatic wait_stream(input string name);
        int budget = 0;
        while (exp_card.size() > 0 && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        check({name, " stream complete"}, exp_card.size(), 0);
    endtask

    task automatic check_perm(input string name);
        int seen [52];
        int bad = 0;
        for (int k = 0; k < 52; k++) seen[k] = 0;
        foreach (cap[k]) begin
            if (cap[k] >= 0 && cap[k] < 52) seen[cap[k]]++;
            else bad++;
        end
        for (int k = 0; k < 52; k++) if (seen[k] != 1) bad++;
        check({name, " perm size"}, cap.size(), 52);
        check({name, " perm unique"}, bad, 0);
    endtask

    function automatic int count_diff(input int x [$], input int y [$]);
        int d = 0;
        if (x.size() != y.size()) return 99;
        foreach (x[k]) if (x[k] != y[k]) d++;
        return d;
    endfunction

    // Monitor: pops one expected card per cycle while loadFlag is high.
    initial begin
        int e;
        forever begin
            @(posedge clk);
            #2;
            if (!rst && bus.loadFlag === 1'b1) begin
                if (!prev_load && exp_rise.size() > 0) begin
                    e = exp_rise.pop_front();
                    check("loadFlag rise edge", ecount, e);
                end
                if (exp_card.size() > 0) begin
                    e = exp_card.pop_front();
                    check("streamed card", {26'd0, bus.card}, e);
                    if (pop_n % HOLD == 0) cap.push_back(int'(bus.card));
                    pop_n++;
                end else begin
                    check("done holds last card", {26'd0, bus.card}, last_card);
                end
            end
            prev_load = bus.loadFlag;
        end
    end

    initial begin
        #500_000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] t0;
        int wb;
        bus.shuffleFlag = 1'b0;
        #23;
        check("reset loadFlag", {31'd0, bus.loadFlag}, 0);
        check("reset card", {26'd0, bus.card}, 63);
        check("reset time_ms", bus.time_ms, 0);
        @(negedge clk);
        rst = 1'b0;

        repeat (4) @(posedge clk);
        #1 check("time_ms after 4 cycles", bus.time_ms, 1);
        repeat (96) @(posedge clk);
        #1 check("time_ms after 100 cycles", bus.time_ms, 25);

        // Run A: full stream, stays in DONE, then dropped.
        wait_ecount(100);
        start_shuffle();
        wait_stream("run A");
        check_perm("run A");
        run_a = cap;
        repeat (5) @(negedge clk);
        bus.shuffleFlag = 1'b0;
        @(negedge clk);
        check("idle loadFlag after drop", {31'd0, bus.loadFlag}, 0);
        check("idle keeps last card", {26'd0, bus.card}, last_card);

        // Run B: re-request 7 cycles later; flag released mid-shuffle.
        repeat (7) @(negedge clk);
        start_shuffle();
        repeat (60) @(negedge clk);
        bus.shuffleFlag = 1'b0;
        wait_stream("run B");
        check_perm("run B");
        run_b = cap;
        check("reshuffle differs", {31'd0, count_diff(run_a, run_b) != 0}, 1);
        repeat (3) @(negedge clk);
        check("idle after mid-shuffle drop", {31'd0, bus.loadFlag}, 0);

        // Reset in the middle of SWAP, then an identically timed request.
        rst = 1'b1;
        #3;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wait_ecount(100);
        start_shuffle();
        while (ecount < 200) @(posedge clk);
        #3;
        rst = 1'b1;
        bus.shuffleFlag = 1'b0;
        exp_card.delete();
        exp_rise.delete();
        #1;
        check("mid-swap reset loadFlag", {31'd0, bus.loadFlag}, 0);
        check("mid-swap reset card", {26'd0, bus.card}, 63);
        check("mid-swap reset time_ms", bus.time_ms, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_ecount(100);
        start_shuffle();
        wait_stream("run C");
        check_perm("run C");
        check("same seed same sequence", count_diff(run_a, cap), 0);
        bus.shuffleFlag = 1'b0;

        // Counter wrap: force all-ones just after a tick, expect 0 on the next.
        t0 = bus.time_ms;
        wb = 0;
        while (bus.time_ms == t0 && wb < 10) begin
            @(negedge clk);
            wb++;
        end
        check("ms tick seen", {31'd0, bus.time_ms != t0}, 1);
        force dut.time_ms_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.time_ms_q;
        repeat (2) @(negedge clk);
        check("time_ms before wrap", bus.time_ms, 32'hFFFF_FFFF);
        @(negedge clk);
        check("time_ms wraps to 0", bus.time_ms, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
